// File: rtl/seg7_scan_decoder_pkg.sv
// Shared 7-segment code table (active-low, bit0=a .. bit6=g), used by both the BCD encoder
// and this scan decoder so the two ends of the loop-back always agree on one table.
package seg7_scan_decoder_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] BAD_DIGIT = 4'hF;

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational active-low segment pattern to BCD decode; anything outside 0..9 (blank included)
// reports legal=0.
module seg7_to_bcd
  import seg7_scan_decoder_pkg::*;
(
  input  logic [6:0] seg_n,
  output logic [3:0] value,
  output logic       legal
);

  always_comb begin
    value = 4'd0;
    legal = 1'b1;
    case (seg_n)
      SEG_0:   value = 4'd0;
      SEG_1:   value = 4'd1;
      SEG_2:   value = 4'd2;
      SEG_3:   value = 4'd3;
      SEG_4:   value = 4'd4;
      SEG_5:   value = 4'd5;
      SEG_6:   value = 4'd6;
      SEG_7:   value = 4'd7;
      SEG_8:   value = 4'd8;
      SEG_9:   value = 4'd9;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Samples a multiplexed active-low 7-seg bus, waits for a stable digit, and records the BCD
// value per anode position with frame and error reporting.
module seg7_scan_decoder
  import seg7_scan_decoder_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg_n,
  input  logic [NUM_DIGITS-1:0]   an_n,
  input  logic                    clr_err,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    update,
  output logic                    frame_done,
  output logic                    err_pulse,
  output logic                    err_sticky
);

  localparam int SW = 7 + NUM_DIGITS;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_HOLD} state_t;

  state_t                          state, state_nx;
  logic [7:0]                      cnt, cnt_nx;
  logic [SW-1:0]                   s1, s2, prev;
  logic [6:0]                      seg_s;
  logic [NUM_DIGITS-1:0]           an_s;
  logic                            one_hot, changed, capture;
  logic [IW-1:0]                   idx;
  logic [NUM_DIGITS-1:0]           cap_mask, seen;
  logic [3:0]                      value;
  logic                            legal;
  logic [NUM_DIGITS-1:0][3:0]      digit_r;

  // Two-flop synchronisers; idle level is all ones so reset looks like a dark bus.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1   <= '1;
      s2   <= '1;
      prev <= '1;
    end else begin
      s1   <= {seg_n, an_n};
      s2   <= s1;
      prev <= s2;
    end
  end

  assign seg_s   = s2[SW-1:NUM_DIGITS];
  assign an_s    = s2[NUM_DIGITS-1:0];
  assign one_hot = $onehot(~an_s);
  assign changed = (s2 != prev);

  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (!an_s[i]) idx = IW'(i);
  end

  seg7_to_bcd u_dec (
    .seg_n (seg_s),
    .value (value),
    .legal (legal)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // The capture cycle needs one more matching sample after the counter saturates, which
  // places update at 2 sync + STABLE_CYCLES + 1 clocks after a clean input edge.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    capture  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (one_hot) begin
          state_nx = ST_SETTLE;
          cnt_nx   = 8'd1;
        end
      end
      ST_SETTLE, ST_HOLD: begin
        if (changed) begin
          if (one_hot) begin
            state_nx = ST_SETTLE;
            cnt_nx   = 8'd1;
          end else begin
            state_nx = ST_IDLE;
            cnt_nx   = 8'd0;
          end
        end else if (state == ST_SETTLE) begin
          if (cnt == 8'(STABLE_CYCLES)) begin
            capture  = 1'b1;
            state_nx = ST_HOLD;
          end else begin
            cnt_nx = cnt + 8'd1;
          end
        end
      end
      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = 8'd0;
      end
    endcase
  end

  assign cap_mask = capture ? ~an_s : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      digit_r     <= '0;
      digit_valid <= '0;
      update      <= 1'b0;
      err_pulse   <= 1'b0;
      err_sticky  <= 1'b0;
      seen        <= '0;
      frame_done  <= 1'b0;
    end else begin
      update     <= capture;
      err_pulse  <= capture & ~legal;
      err_sticky <= (err_sticky & ~clr_err) | err_pulse;
      frame_done <= &seen;
      // A capture landing in the clearing cycle belongs to the new frame.
      seen       <= ((&seen) ? '0 : seen) | cap_mask;
      if (capture) begin
        digit_r[idx]     <= legal ? value : BAD_DIGIT;
        digit_valid[idx] <= legal;
      end
    end
  end

  assign digits = digit_r;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Self-checking bench: directed scenarios plus randomized bus traffic, all scored every cycle
// against a run-length reference model of the decoder.
module tb_seg7_scan_decoder;

  localparam int ND = 4;
  localparam int SC = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [6:0]    seg_n;
  logic [ND-1:0] an_n;
  logic          clr_err;
  logic [4*ND-1:0] digits;
  logic [ND-1:0] digit_valid;
  logic          update, frame_done, err_pulse, err_sticky;

  seg7_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_n       (seg_n),
    .an_n        (an_n),
    .clr_err     (clr_err),
    .digits      (digits),
    .digit_valid (digit_valid),
    .update      (update),
    .frame_done  (frame_done),
    .err_pulse   (err_pulse),
    .err_sticky  (err_sticky)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: capture when a one-hot sample has repeated SC+1 times in a row.
  bit [6:0]  codes [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  bit [10:0] hist[$];
  bit [10:0] last_smp;
  int        run;
  bit [3:0]  m_dig [ND];
  bit [ND-1:0] m_val, m_seen;
  bit        m_upd, m_fd, m_err, m_sticky;

  function automatic int decode(input bit [6:0] s);
    for (int i = 0; i < 10; i++) if (codes[i] == s) return i;
    return -1;
  endfunction

  task automatic reset_model();
    hist.delete();
    last_smp = '1;
    run = 0;
    for (int i = 0; i < ND; i++) m_dig[i] = 4'h0;
    m_val = '0; m_seen = '0;
    m_upd = 0; m_fd = 0; m_err = 0; m_sticky = 0;
  endtask

  task automatic compare_all(input string pfx);
    logic [4*ND-1:0] ed;
    for (int i = 0; i < ND; i++) ed[4*i +: 4] = m_dig[i];
    chk({pfx, "_digits"}, 32'(digits), 32'(ed));
    chk({pfx, "_valid"}, 32'(digit_valid), 32'(m_val));
    chk({pfx, "_update"}, 32'(update), 32'(m_upd));
    chk({pfx, "_frame"}, 32'(frame_done), 32'(m_fd));
    chk({pfx, "_errp"}, 32'(err_pulse), 32'(m_err));
    chk({pfx, "_sticky"}, 32'(err_sticky), 32'(m_sticky));
  endtask

  task automatic step();
    bit [10:0] smp;
    bit        clr_now, cap;
    int        zeros, pos, v;
    if (!rst) begin
      @(posedge clk);
      reset_model();
      #1 compare_all("rst");
      return;
    end
    hist.push_back({seg_n, an_n});
    clr_now = clr_err;
    @(posedge clk);
    if (hist.size() > 3) void'(hist.pop_front());
    smp = (hist.size() == 3) ? hist[0] : '1;
    run = (smp == last_smp) ? run + 1 : 1;
    if (run > 1000) run = 1000;
    last_smp = smp;
    zeros = 0; pos = 0;
    for (int i = 0; i < ND; i++) if (!smp[i]) begin zeros++; pos = i; end
    cap = (zeros == 1) && (run == SC + 1);
    m_sticky = (m_sticky && !clr_now) || m_err;
    m_fd = (m_seen == '1);
    if (m_fd) m_seen = '0;
    m_upd = cap;
    m_err = 0;
    if (cap) begin
      v = decode(smp[10:4]);
      if (v < 0) begin
        m_dig[pos] = 4'hF; m_val[pos] = 0; m_err = 1;
      end else begin
        m_dig[pos] = 4'(v); m_val[pos] = 1;
      end
      m_seen[pos] = 1;
    end
    #1 compare_all("cyc");
  endtask

  task automatic drive(input bit [6:0] s, input bit [ND-1:0] a);
    seg_n = s;
    an_n  = a;
  endtask

  int n_upd, first_upd, n_fd, fd_cyc, last_upd;
  bit seen_err;

  initial begin
    rst = 1'b0; seg_n = $urandom; an_n = $urandom; clr_err = 1'b0;
    reset_model();

    // 1: reset with random inputs, then idle bus
    for (int i = 0; i < 4; i++) begin
      seg_n = $urandom; an_n = $urandom; clr_err = $urandom;
      step();
    end
    chk("t1_rst_digits", 32'(digits), 0);
    chk("t1_rst_update", 32'(update), 0);
    @(negedge clk);
    rst = 1'b1; clr_err = 1'b0;
    drive(7'h7F, 4'hF);
    n_upd = 0;
    for (int i = 0; i < 10; i++) begin step(); n_upd += update; end
    chk("t1_idle_noupd", 32'(n_upd), 0);

    // 2: clean capture latency
    drive(7'b0100100, 4'b1101);
    n_upd = 0; first_upd = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (update) begin n_upd++; if (first_upd == 0) first_upd = i; end
    end
    chk("t2_latency", 32'(first_upd), 32'(2 + SC + 1));
    chk("t2_nupd", 32'(n_upd), 1);
    chk("t2_digit1", 32'(digits[7:4]), 2);
    chk("t2_valid", 32'(digit_valid), 32'b0010);

    // 3: ghosting then a 10-cycle hold
    n_upd = 0;
    for (int k = 0; k < 4; k++) begin
      drive(codes[k + 4], 4'b1011);
      for (int i = 0; i < 5; i++) begin step(); n_upd += update; end
    end
    chk("t3_ghost_noupd", 32'(n_upd), 0);
    drive(codes[6], 4'b1011);
    for (int i = 0; i < 10; i++) begin step(); n_upd += update; end
    drive(7'h7F, 4'hF);
    for (int i = 0; i < 5; i++) begin step(); n_upd += update; end
    chk("t3_single_cap", 32'(n_upd), 1);
    chk("t3_digit2", 32'(digits[11:8]), 6);

    // 4: full-frame scans
    for (int r = 0; r < 2; r++) begin
      n_fd = 0; fd_cyc = -1; last_upd = -1;
      for (int d = 0; d < 4; d++) begin
        drive(codes[(d == 0) ? 7 : (d == 1) ? 3 : (d == 2) ? 0 : 9], ~(4'b1 << d));
        for (int i = 0; i < 12; i++) begin
          step();
          if (update) last_upd = d * 12 + i;
          if (frame_done) begin n_fd++; fd_cyc = d * 12 + i; end
        end
      end
      drive(7'h7F, 4'hF);
      for (int i = 0; i < 4; i++) begin
        step();
        if (frame_done) begin n_fd++; fd_cyc = 48 + i; end
      end
      chk("t4_digits", 32'(digits), 32'h9037);
      chk("t4_valid", 32'(digit_valid), 32'hF);
      chk("t4_nframe", 32'(n_fd), 1);
      chk("t4_frame_lag", 32'(fd_cyc), 32'(last_upd + 1));
    end

    // 5: blank pattern, error flags, clear priority
    drive(7'b1111111, 4'b1110);
    seen_err = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (err_pulse) seen_err = 1;
      clr_err = m_err;
    end
    clr_err = 1'b0;
    chk("t5_err_seen", 32'(seen_err), 1);
    chk("t5_digit0", 32'(digits[3:0]), 32'hF);
    chk("t5_valid0", 32'(digit_valid[0]), 0);
    chk("t5_sticky_setwins", 32'(err_sticky), 1);
    drive(7'h7F, 4'hF);
    step(); step();
    clr_err = 1'b1; step(); clr_err = 1'b0;
    chk("t5_sticky_clr", 32'(err_sticky), 0);

    // 6: multi-anode ignored; async reset mid-SETTLE
    drive(codes[8], 4'b1100);
    n_upd = 0;
    for (int i = 0; i < 12; i++) begin step(); n_upd += update; end
    chk("t6_multi_noupd", 32'(n_upd), 0);
    drive(codes[5], 4'b0111);
    for (int i = 0; i < 6; i++) step();
    #2 rst = 1'b0;
    reset_model();
    #1 compare_all("t6_async");
    for (int i = 0; i < 3; i++) step();
    @(negedge clk);
    rst = 1'b1;
    n_upd = 0;
    for (int i = 0; i < 14; i++) begin step(); n_upd += update; end
    chk("t6_post_rst_cap", 32'(n_upd), 1);

    // Randomized bus traffic
    for (int s = 0; s < 180; s++) begin
      int hold;
      if ($urandom_range(0, 9) < 7) an_n = ~(4'b1 << $urandom_range(0, ND - 1));
      else an_n = 4'($urandom);
      if ($urandom_range(0, 3) != 0) seg_n = codes[$urandom_range(0, 9)];
      else seg_n = 7'($urandom);
      hold = $urandom_range(1, 14);
      for (int i = 0; i < hold; i++) begin
        clr_err = ($urandom_range(0, 7) == 0);
        step();
      end
      if ($urandom_range(0, 49) == 0) begin
        #2 rst = 1'b0;
        reset_model();
        #1 compare_all("rnd_async");
        step();
        @(negedge clk);
        rst = 1'b1;
      end
    end
    clr_err = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
